// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 4;

  // Bits needed to hold an iteration count from 0 to w inclusive.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration: conditional add of M into A, then shift {A,Q} right.
module mult_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum_s;

  // Add when the multiplier LSB is set; the carry lands in A's MSB before the shift.
  always_comb begin
    sum_s = a_i;
    if (q_i[0]) begin
      sum_s = a_i + {1'b0, m_i};
    end else begin
      sum_s = a_i;
    end
    a_o = {1'b0, sum_s[WIDTH:1]};
    q_o = {sum_s[0], q_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier, free-running or single-stepped, with live display state.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [WIDTH-1:0]            mcand,
  input  logic [WIDTH-1:0]            mplier,
  input  logic                        step_en,
  input  logic                        step,
  output logic                        busy,
  output logic                        done,
  output logic                        led,
  output logic [cnt_w(WIDTH)-1:0]     count,
  output logic [2*WIDTH-1:0]          disp_num,
  output logic [2*WIDTH-1:0]          product
);

  localparam int CW = cnt_w(WIDTH);

  state_t               state_q;
  logic [WIDTH-1:0]     m_q;
  logic [WIDTH:0]       a_q;
  logic [WIDTH-1:0]     q_q;
  logic [CW-1:0]        count_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 led_q;
  logic [2*WIDTH-1:0]   disp_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH:0]       a_d;
  logic [WIDTH-1:0]     q_d;
  logic [CW-1:0]        count_d;
  logic                 iter_en_s;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .a_i (a_q),
    .q_i (q_q),
    .m_i (m_q),
    .a_o (a_d),
    .q_o (q_d)
  );

  // Iteration gating and the incremented count.
  always_comb begin
    iter_en_s = (!step_en) || step;
    count_d   = count_q + CW'(1);
  end

  // FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= 1'b0;
      disp_q    <= '0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          // A simultaneous step pulse is deliberately dropped: the load wins.
          if (start) begin
            m_q     <= mcand;
            a_q     <= '0;
            q_q     <= mplier;
            count_q <= '0;
            disp_q  <= {{WIDTH{1'b0}}, mplier};
            busy_q  <= 1'b1;
            led_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (iter_en_s) begin
            a_q     <= a_d;
            q_q     <= q_d;
            count_q <= count_d;
            disp_q  <= {a_d[WIDTH-1:0], q_d};
            if (count_d == CW'(WIDTH)) begin
              product_q <= {a_d[WIDTH-1:0], q_d};
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              led_q     <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign led      = led_q;
  assign count    = count_q;
  assign disp_num = disp_q;
  assign product  = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: table vectors, random runs, and corner sequences.
module tb_seq_multiplier;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic            step_en;
  logic            step;
  logic            busy;
  logic            done;
  logic            led;
  logic [CW-1:0]   count;
  logic [2*W-1:0]  disp_num;
  logic [2*W-1:0]  product;

  int n_vec = 0;
  int n_bad = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .step_en  (step_en),
    .step     (step),
    .busy     (busy),
    .done     (done),
    .led      (led),
    .count    (count),
    .disp_num (disp_num),
    .product  (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Display value after i iterations: partial product of the low i multiplier bits,
  // aligned to the top, with the unconsumed multiplier bits below it.
  function automatic logic [2*W-1:0] partial(input int m, input int q, input int i);
    logic [31:0] v;
    int lowq;
    lowq = q % (1 << i);
    v = 32'((m * lowq) << (W - i)) + 32'(q >> i);
    return v[2*W-1:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},    32'(busy),     32'd0);
    chk({tag, "_done"},    32'(done),     32'd0);
    chk({tag, "_led"},     32'(led),      32'd0);
    chk({tag, "_count"},   32'(count),    32'd0);
    chk({tag, "_disp"},    32'(disp_num), 32'd0);
    chk({tag, "_product"}, 32'(product),  32'd0);
  endtask

  // mode 0: free-run; 1: step mode with random pulses; 2: step_en and step both random.
  task automatic run_op(input int m, input int q, input int mode, input logic [31:0] exp_p,
                        input string tag);
    int it;
    int cyc;
    bit en;
    @(negedge clk);
    mcand   = W'(m);
    mplier  = W'(q);
    start   = 1'b1;
    step    = 1'b0;
    step_en = (mode != 0);
    @(negedge clk);
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
    chk({tag, "_load_busy"},  32'(busy),     32'd1);
    chk({tag, "_load_count"}, 32'(count),    32'd0);
    chk({tag, "_load_led"},   32'(led),      32'd0);
    chk({tag, "_load_disp"},  32'(disp_num), 32'(partial(m, q, 0)));
    it  = 0;
    cyc = 0;
    while (it < W && cyc < 200) begin
      case (mode)
        0:       begin step_en = 1'b0; step = 1'b0; end
        1:       begin step_en = 1'b1; step = 1'($urandom_range(0, 1)); end
        default: begin step_en = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1)); end
      endcase
      start = 1'($urandom_range(0, 1));
      en = (!step_en) || step;
      @(negedge clk);
      cyc++;
      if (en) it++;
      chk({tag, "_count"}, 32'(count),    32'(it));
      chk({tag, "_disp"},  32'(disp_num), 32'(partial(m, q, it)));
      chk({tag, "_done"},  32'(done),     32'(en && it == W));
      chk({tag, "_busy"},  32'(busy),     32'(it < W));
      chk({tag, "_led"},   32'(led),      32'(it == W));
    end
    start = 1'b0;
    step  = 1'b0;
    if (it < W) chk({tag, "_timeout"}, 32'(it), 32'(W));
    if (mode == 0) chk({tag, "_latency"}, 32'(cyc), 32'(W));
    chk({tag, "_product"}, 32'(product), exp_p);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done),    32'd0);
    chk({tag, "_led_hold"},   32'(led),     32'd1);
    chk({tag, "_prod_hold"},  32'(product), exp_p);
  endtask

  typedef struct {
    int          m;
    int          q;
    int          mode;
    logic [31:0] exp_p;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int m;
    int q;
    tbl[0] = '{3,  5,  0, 32'h0F};
    tbl[1] = '{15, 15, 0, 32'hE1};
    tbl[2] = '{0,  9,  0, 32'h00};
    tbl[3] = '{9,  0,  0, 32'h00};
    tbl[4] = '{7,  6,  1, 32'h2A};
    tbl[5] = '{9,  9,  2, 32'h51};
    tbl[6] = '{5,  6,  2, 32'h1E};
    tbl[7] = '{15, 1,  1, 32'h0F};

    reset = 1'b1; start = 1'b0; step_en = 1'b0; step = 1'b0;
    mcand = '0; mplier = '0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_op(tbl[i].m, tbl[i].q, tbl[i].mode, tbl[i].exp_p, "tbl");

    for (int i = 0; i < 20; i++) begin
      m = int'($urandom_range(0, 15));
      q = int'($urandom_range(0, 15));
      run_op(m, q, int'($urandom_range(0, 2)), 32'(m * q), "rnd");
    end

    // Start and step together in DONE: load wins, step not counted.
    @(negedge clk);
    mcand = 4'd2; mplier = 4'd3; step_en = 1'b1; step = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; step = 1'b0;
    chk("startstep_count", 32'(count),    32'd0);
    chk("startstep_busy",  32'(busy),     32'd1);
    chk("startstep_disp",  32'(disp_num), 32'h03);
    step_en = 1'b0;
    repeat (W) @(negedge clk);
    chk("startstep_done",    32'(done),    32'd1);
    chk("startstep_product", 32'(product), 32'h06);

    // Asynchronous reset after the second iteration of 9x9.
    @(negedge clk);
    mcand = 4'd9; mplier = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_count", 32'(count), 32'd2);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_rst");
    run_op(9, 9, 0, 32'h51, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential shift-and-add unsigned multiplier. It is the inverse counterpart of the lab's shift-subtract divider. It sits behind the same button/switch front end: operands come from the board's operand registers, and the live partial state is driven to the 7-segment display path. It runs either free (one iteration per clock) or single-stepped (one iteration per `step` pulse), so students can watch the product build up bit by bit.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits. The product is 2*WIDTH bits.

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `reset`  input  1: asynchronous, active-high; clears all state immediately.
- `start`  input  1: level-sampled in IDLE or DONE; begins a multiplication.
- `mcand`  input  WIDTH: multiplicand M, captured on the start edge.
- `mplier`  input  WIDTH: multiplier Q, captured on the start edge.
- `step_en`  input  1: 1 = single-step mode; 0 = free-run.
- `step`  input  1: one-cycle pulse, already synchronised and debounced upstream; advances one iteration when `step_en`=1.
- `busy`  output  1: high in RUN.
- `done`  output  1: one-cycle pulse when the product becomes valid.
- `led`  output  1: high while in DONE.
- `count`  output  $clog2(WIDTH+1): iterations completed.
- `disp_num`  output  2*WIDTH: live {A[WIDTH-1:0], Q} for display.
- `product`  output  2*WIDTH: final result, held until the next start.

## Operation
- Internal registers: M (WIDTH bits), A (WIDTH+1 bits, carry in MSB), Q (WIDTH bits), count, state.
- FSM states and transitions:
  - IDLE: reset state. `start`=1 loads the operands and moves to RUN.
  - RUN: performs iterations. Moves to DONE when count reaches WIDTH.
  - DONE: holds `led`=1. `start`=1 reloads the operands and moves to RUN; otherwise stays in DONE.
- Load action: A←0, Q←`mplier`, M←`mcand`, count←0.
- Iteration, with the add and shift applied in the same clock:
  - If Q[0]=1, A←A+M (WIDTH+1-bit add, no overflow possible).
  - Then {A,Q} is shifted right by 1, with a zero entering the MSB of A.
  - count←count+1.
- Iteration enable in RUN: (`step_en`=0) OR (`step`=1). When the enable is low, all registers hold.
- Completion: the iteration that brings count to WIDTH also sets `product`←{A,Q} (post-shift value), pulses `done`, and moves to DONE.
- `start` in RUN is ignored. Operand changes during RUN are ignored.
- A change of `step_en` mid-run takes effect on the next cycle. No iteration is lost or duplicated.
- Unsigned arithmetic only. Zero operands run the full WIDTH iterations; there is no early exit.
- Reset values: `busy`=0, `done`=0, `led`=0, `count`=0, `disp_num`=0, `product`=0, state=IDLE.

## Timing
- Start sampled at edge k: registers are loaded at k and `busy`=1 after k.
- Free-run: iterations occur at edges k+1 … k+WIDTH. After edge k+WIDTH:
  - `product` is valid and `done`=1 for exactly one cycle.
  - `busy`=0 and `led`=1.
  - Latency from start edge to `done` is WIDTH cycles; the total occupancy is WIDTH+1 cycles including the load.
- Step mode: exactly one iteration per cycle with `step`=1. `done` is asserted after the edge that samples the WIDTH-th step.
- `disp_num` and `count` update on the same edge as the iteration. They are registered outputs with no combinational paths from inputs.
- `reset` asserted at any point, including mid-RUN: all outputs drop to their reset values without waiting for `clk`. Operation resumes from IDLE after release.
- `start` and a `step` pulse in the same cycle in DONE: the load wins. The step pulse is not counted.

## Structure
- Shared package `mult_pkg`:
  - state enum {IDLE, RUN, DONE};
  - the `WIDTH` default constant;
  - the count-width helper.
- One natural sub-module, `mult_step`: a combinational single iteration. It maps (A, Q, M) to the next (A, Q) and is reusable by a future combinational array version. The top level holds the FSM and registers.

## Test plan
- Free-run, WIDTH=4, 3×5 → `done` 4 cycles after the start edge, `product`=0x0F, `led`=1, `count`=4.
- 15×15 → `product`=0xE1 (225). 0×9 and 9×0 → `product`=0x00 after the full 4 iterations.
- Step mode, 7×6 → `disp_num` moves only on `step` pulses:
  - `count` runs 1, 2, 3, 4;
  - after the 4th pulse, `product`=0x2A.
  - Idle cycles between pulses leave the state unchanged.
- `start` pulsed mid-RUN with new operands → ignored; the original product completes. `start` in DONE → a new run with the new operands.
- `reset` asserted after the 2nd iteration of 9×9 → all outputs 0 immediately and state IDLE. A subsequent start with 9×9 yields 0x51.
- `step_en` toggled 0→1→0 mid-run → exactly 4 iterations in total and the correct product.
